// File: rtl/sram_pingpong_ctrl.sv
// sram_pingpong_ctrl
//   Ping-pong scheduler for two external asynchronous SRAM banks. The writer
//   (ADC sample stream) fills bank wr_bank while the reader (USB readout) drains
//   the other bank. The banks swap once the writer has filled a frame and the
//   reader has drained its frame, or holds no frame at all. All SRAM strobe
//   timing is generated here, and the SRAM pins connect directly.
// Ports
//   ifclk, reset_n          clock (rising edge) and asynchronous active-low reset
//   wr_valid/wr_data/wr_ready  sample input; a sample is accepted on valid & ready
//   rd_valid/rd_data/rd_ready  frame word output; a word is consumed on valid & ready
//   wr_bank                 bank owned by the writer (the reader owns ~wr_bank)
//   frame_rdy               one-cycle pulse on each bank swap
//   ovf                     sticky: a sample was offered while wr_ready was low
//   ramd*/rama*/ramwe*/ramoe*  SRAM data (tri-state), address, and active-low
//                           write and output enables for bank 0 and bank 1
module sram_pingpong_ctrl #(
    parameter int AW        = 19,
    parameter int DW        = 16,
    parameter int FRAME_LEN = 1024,
    parameter int RD_WAIT   = 2
) (
    input  logic          ifclk,
    input  logic          reset_n,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          rd_ready,
    output logic          wr_bank,
    output logic          frame_rdy,
    output logic          ovf,
    inout  wire  [DW-1:0] ramd0,
    output logic [AW-1:0] rama0,
    output logic          ramwe0,
    output logic          ramoe0,
    inout  wire  [DW-1:0] ramd1,
    output logic [AW-1:0] rama1,
    output logic          ramwe1,
    output logic          ramoe1
);

    localparam int CW  = $clog2(FRAME_LEN + 1);
    localparam int ACW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [CW-1:0]  FRAME_END = CW'(FRAME_LEN);
    localparam logic [CW-1:0]  LAST_WORD = CW'(FRAME_LEN - 1);
    localparam logic [ACW-1:0] ACC_LAST  = ACW'(RD_WAIT - 1);

    typedef enum logic [1:0] {W_IDLE, W_SETUP, W_STROBE, W_HOLD} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACC, R_OUT} r_state_t;

    w_state_t        w_state_q, w_state_d;
    r_state_t        r_state_q, r_state_d;
    logic            swap_q, swap_d;
    logic            wr_bank_q, wr_bank_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic [ACW-1:0]  acc_cnt_q, acc_cnt_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_full_q, rd_full_d;   // reader bank holds an unread frame
    logic            frame_rdy_q, frame_rdy_d;
    logic            ovf_q, ovf_d;
    logic            wr_ready_q, wr_ready_d;
    logic [AW-1:0]   rama_q [2];
    logic [AW-1:0]   rama_d [2];
    logic [1:0]      ramwe_q, ramwe_d;
    logic [1:0]      ramoe_q, ramoe_d;
    logic [1:0]      drv_q, drv_d;           // controller drives ramd of that bank
    logic [DW-1:0]   ramd_in [2];

    logic wb, rb;
    assign wb = wr_bank_q;
    assign rb = ~wr_bank_q;

    assign ramd_in[0] = ramd0;
    assign ramd_in[1] = ramd1;

    always_comb begin
        w_state_d   = w_state_q;
        r_state_d   = r_state_q;
        swap_d      = swap_q;
        wr_bank_d   = wr_bank_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        acc_cnt_d   = acc_cnt_q;
        wdata_d     = wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        rd_full_d   = rd_full_q;
        frame_rdy_d = 1'b0;
        ovf_d       = ovf_q;
        wr_ready_d  = wr_ready_q;
        rama_d      = rama_q;
        ramwe_d     = ramwe_q;
        ramoe_d     = ramoe_q;
        drv_d       = drv_q;

        // Any sample offered while not ready is lost, including on the SWAP cycle.
        if (wr_valid && !wr_ready_q)
            ovf_d = 1'b1;

        if (swap_q) begin
            // Both FSMs are idle here, so every strobe is already inactive.
            swap_d      = 1'b0;
            wr_bank_d   = ~wr_bank_q;
            wcnt_d      = '0;
            rcnt_d      = '0;
            rd_full_d   = 1'b1;
            frame_rdy_d = 1'b1;
            wr_ready_d  = 1'b1;
        end else begin
            unique case (w_state_q)
                W_IDLE: begin
                    if (wr_valid && wr_ready_q) begin
                        wdata_d     = wr_data;
                        rama_d[wb]  = AW'(wcnt_q);
                        drv_d[wb]   = 1'b1;
                        ramwe_d[wb] = 1'b1;
                        wr_ready_d  = 1'b0;
                        w_state_d   = W_SETUP;
                    end
                end
                W_SETUP: begin
                    ramwe_d[wb] = 1'b0;
                    w_state_d   = W_STROBE;
                end
                W_STROBE: begin
                    ramwe_d[wb] = 1'b1;
                    w_state_d   = W_HOLD;
                end
                W_HOLD: begin
                    drv_d[wb]  = 1'b0;
                    wcnt_d     = wcnt_q + 1'b1;
                    // The final word leaves the writer done; it is not ready again until a swap.
                    wr_ready_d = (wcnt_q != LAST_WORD);
                    w_state_d  = W_IDLE;
                end
                default: w_state_d = W_IDLE;
            endcase

            unique case (r_state_q)
                R_IDLE: begin
                    if (rd_full_q && (rcnt_q < FRAME_END)) begin
                        rama_d[rb]  = AW'(rcnt_q);
                        ramoe_d[rb] = 1'b0;
                        acc_cnt_d   = '0;
                        r_state_d   = R_ACC;
                    end
                end
                R_ACC: begin
                    // Sample on the last oe-low cycle so oe is low for exactly RD_WAIT cycles.
                    if (acc_cnt_q == ACC_LAST) begin
                        rd_data_d   = ramd_in[rb];
                        ramoe_d[rb] = 1'b1;
                        rd_valid_d  = 1'b1;
                        r_state_d   = R_OUT;
                    end else begin
                        acc_cnt_d = acc_cnt_q + 1'b1;
                    end
                end
                R_OUT: begin
                    if (rd_ready) begin
                        rd_valid_d = 1'b0;
                        rcnt_d     = rcnt_q + 1'b1;
                        if (rcnt_q == LAST_WORD)
                            rd_full_d = 1'b0;
                        r_state_d = R_IDLE;
                    end
                end
                default: r_state_d = R_IDLE;
            endcase

            // The writer is done and the reader bank is drained or empty.
            if ((w_state_q == W_IDLE) && (wcnt_q == FRAME_END) &&
                !rd_full_q && (r_state_q == R_IDLE))
                swap_d = 1'b1;
        end
    end

    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            swap_q      <= 1'b0;
            wr_bank_q   <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            acc_cnt_q   <= '0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_full_q   <= 1'b0;
            frame_rdy_q <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ready_q  <= 1'b1;
            rama_q[0]   <= '0;
            rama_q[1]   <= '0;
            ramwe_q     <= 2'b11;
            ramoe_q     <= 2'b11;
            drv_q       <= 2'b00;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            swap_q      <= swap_d;
            wr_bank_q   <= wr_bank_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            acc_cnt_q   <= acc_cnt_d;
            wdata_q     <= wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_full_q   <= rd_full_d;
            frame_rdy_q <= frame_rdy_d;
            ovf_q       <= ovf_d;
            wr_ready_q  <= wr_ready_d;
            rama_q      <= rama_d;
            ramwe_q     <= ramwe_d;
            ramoe_q     <= ramoe_d;
            drv_q       <= drv_d;
        end
    end

    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign wr_bank   = wr_bank_q;
    assign frame_rdy = frame_rdy_q;
    assign ovf       = ovf_q;

    assign rama0  = rama_q[0];
    assign rama1  = rama_q[1];
    assign ramwe0 = ramwe_q[0];
    assign ramwe1 = ramwe_q[1];
    assign ramoe0 = ramoe_q[0];
    assign ramoe1 = ramoe_q[1];
    assign ramd0  = drv_q[0] ? wdata_q : {DW{1'bz}};
    assign ramd1  = drv_q[1] ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_sram_pingpong_ctrl.sv
// Bench for sram_pingpong_ctrl with FRAME_LEN=4 and RD_WAIT=2. Two async SRAM
// models sit on the bank pins. Accepted samples go into a scoreboard queue and
// are compared in order against every word the reader hands out.
module tb_sram_pingpong_ctrl;

    localparam int AW = 19;
    localparam int DW = 16;
    localparam int FL = 4;
    localparam int RW = 2;

    logic          ifclk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_ready = 1'b0;
    logic          wr_ready, rd_valid, wr_bank, frame_rdy, ovf;
    logic [DW-1:0] rd_data;
    wire  [DW-1:0] ramd0, ramd1;
    logic [AW-1:0] rama0, rama1;
    logic          ramwe0, ramwe1, ramoe0, ramoe1;

    sram_pingpong_ctrl #(.AW(AW), .DW(DW), .FRAME_LEN(FL), .RD_WAIT(RW)) dut (
        .ifclk(ifclk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_bank(wr_bank), .frame_rdy(frame_rdy), .ovf(ovf),
        .ramd0(ramd0), .rama0(rama0), .ramwe0(ramwe0), .ramoe0(ramoe0),
        .ramd1(ramd1), .rama1(rama1), .ramwe1(ramwe1), .ramoe1(ramoe1)
    );

    always #5 ifclk = ~ifclk;

    // Async SRAM models: they drive data while oe is low and we is high.
    logic [DW-1:0] mem [2][16];
    assign ramd0 = (!ramoe0 && ramwe0) ? mem[0][rama0[3:0]] : {DW{1'bz}};
    assign ramd1 = (!ramoe1 && ramwe1) ? mem[1][rama1[3:0]] : {DW{1'bz}};

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard, and frame swap tracking.
    logic [DW-1:0] exp_q [$];
    logic          exp_bank = 1'b0;
    logic          prev_fr  = 1'b0;
    int            fr_count = 0;
    int            rd_count = 0;

    always @(negedge ifclk) begin
        if (!reset_n) begin
            exp_bank = 1'b0;
            prev_fr  = 1'b0;
        end else begin
            if (wr_valid && wr_ready) begin
                exp_q.push_back(wr_data);
                $display("wr: bank=%0d data=0x%04h", wr_bank, wr_data);
            end
            if (rd_valid && rd_ready) begin
                rd_count++;
                if (exp_q.size() == 0) begin
                    check_eq("rd_q_depth", exp_q.size(), 1);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    $display("rd: data=0x%04h expected=0x%04h", rd_data, e);
                    check_eq("rd_data", rd_data, e);
                end
            end
            if (frame_rdy) begin
                fr_count++;
                exp_bank = ~exp_bank;
                check_eq("swap_bank", wr_bank, exp_bank);
                check_eq("frame_rdy_pulse", prev_fr, 0);
            end
            prev_fr = frame_rdy;
        end
    end

    // Strobe timing monitor: it checks address and data stability around we=0,
    // the oe width, and that we and oe are never low together. It also writes
    // the SRAM model.
    logic          prev_we [2];
    logic          pend    [2];
    logic [AW-1:0] prev_addr [2];
    logic [AW-1:0] pend_addr [2];
    logic [DW-1:0] prev_data [2];
    logic [DW-1:0] pend_data [2];
    int            oe_run  [2];

    always @(negedge ifclk) begin
        logic [1:0]    we_v, oe_v;
        logic [AW-1:0] a_v [2];
        logic [DW-1:0] d_v [2];
        we_v = {ramwe1, ramwe0};
        oe_v = {ramoe1, ramoe0};
        a_v[0] = rama0; a_v[1] = rama1;
        d_v[0] = ramd0; d_v[1] = ramd1;
        for (int b = 0; b < 2; b++) begin
            if (!reset_n) begin
                pend[b]   = 1'b0;
                oe_run[b] = 0;
            end else begin
                if (!we_v[b]) begin
                    check_eq("wr_setup_we", prev_we[b], 1);
                    check_eq("wr_setup_addr", a_v[b], prev_addr[b]);
                    check_eq("wr_setup_data", d_v[b], prev_data[b]);
                    mem[b][a_v[b][3:0]] = d_v[b];
                    pend[b]      = 1'b1;
                    pend_addr[b] = a_v[b];
                    pend_data[b] = d_v[b];
                end else if (pend[b]) begin
                    check_eq("wr_hold_addr", a_v[b], pend_addr[b]);
                    check_eq("wr_hold_data", d_v[b], pend_data[b]);
                    pend[b] = 1'b0;
                end
                if (!oe_v[b]) begin
                    oe_run[b]++;
                    check_eq("we_oe_excl", we_v[b], 1);
                end else if (oe_run[b] != 0) begin
                    check_eq("oe_width", oe_run[b], RW);
                    oe_run[b] = 0;
                end
            end
            prev_we[b]   = we_v[b];
            prev_addr[b] = a_v[b];
            prev_data[b] = d_v[b];
        end
    end

    task automatic write_word(input logic [DW-1:0] d, output logic bk);
        for (int i = 0; i < 200; i++) begin
            @(posedge ifclk); #1;
            if (wr_ready) break;
        end
        check_eq("wr_ready_wait", wr_ready, 1);
        bk = wr_bank;
        if (wr_ready) begin
            wr_valid = 1'b1;
            wr_data  = d;
            @(posedge ifclk); #1;
            wr_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(posedge ifclk); #1;
            if (exp_q.size() == 0 && !rd_valid) break;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        logic bk;
        int   fr0, rd0;

        // 1: reset state
        reset_n = 1'b0;
        repeat (3) @(posedge ifclk);
        #1;
        check_eq("rst_ramwe0", ramwe0, 1);
        check_eq("rst_ramwe1", ramwe1, 1);
        check_eq("rst_ramoe0", ramoe0, 1);
        check_eq("rst_ramoe1", ramoe1, 1);
        check_eq("rst_wr_ready", wr_ready, 1);
        check_eq("rst_wr_bank", wr_bank, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_rama0", rama0, 0);
        @(posedge ifclk); #1;
        reset_n = 1'b1;

        // 2: one frame into bank 0, then read back while the writer owns bank 1
        rd_ready = 1'b1;
        for (int i = 0; i < FL; i++) write_word(16'hA001 + 16'(i), bk);
        wait_drain("t2_drain");
        for (int k = 0; k < FL; k++) check_eq("t2_mem0", mem[0][k], 32'hA001 + 32'(k));
        check_eq("t2_wr_bank", wr_bank, 1);
        check_eq("t2_frames", fr_count, 1);

        // 3: back-pressure; the writer fills a bank while the reader stalls
        rd_ready = 1'b0;
        for (int i = 0; i < FL; i++) write_word(16'hB001 + 16'(i), bk);
        for (int i = 0; i < 100; i++) begin
            @(posedge ifclk); #1;
            if (rd_valid) break;
        end
        check_eq("t3_rd_valid", rd_valid, 1);
        rd_ready = 1'b1;
        @(posedge ifclk); #1;
        rd_ready = 1'b0;
        for (int i = 0; i < FL; i++) write_word(16'hC001 + 16'(i), bk);
        fr0 = fr_count;
        repeat (20) @(posedge ifclk);
        #1;
        check_eq("t3_wr_ready_low", wr_ready, 0);
        check_eq("t3_no_swap_bank", wr_bank, 0);
        check_eq("t3_no_swap_cnt", fr_count, fr0);
        check_eq("t3_ovf_before", ovf, 0);
        wr_valid = 1'b1;
        wr_data  = 16'hDEAD;
        @(posedge ifclk); #1;
        wr_valid = 1'b0;
        check_eq("t3_ovf_set", ovf, 1);
        rd_ready = 1'b1;
        wait_drain("t3_drain");
        check_eq("t3_ovf_sticky", ovf, 1);
        check_eq("t3_wr_bank", wr_bank, 1);
        check_eq("t3_frames", fr_count, fr0 + 1);

        // 5: reset in the middle of a write strobe
        write_word(16'hD001, bk);
        for (int i = 0; i < 10; i++) begin
            @(posedge ifclk); #1;
            if (!ramwe0 || !ramwe1) break;
        end
        check_eq("t5_in_strobe", ramwe1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t5_ramwe0", ramwe0, 1);
        check_eq("t5_ramwe1", ramwe1, 1);
        check_eq("t5_wr_bank", wr_bank, 0);
        check_eq("t5_wr_ready", wr_ready, 1);
        check_eq("t5_ovf_clr", ovf, 0);
        exp_q.delete();
        @(posedge ifclk); #1;
        reset_n = 1'b1;

        // 6: a continuous 3-frame stream with the consumer always ready
        fr0 = fr_count;
        rd0 = rd_count;
        rd_ready = 1'b1;
        for (int i = 0; i < 3 * FL; i++) begin
            write_word(DW'(i), bk);
            if (i % FL == 0) check_eq("t6_bank", bk, (i / FL) % 2);
        end
        wait_drain("t6_drain");
        check_eq("t6_frames", fr_count - fr0, 3);
        check_eq("t6_reads", rd_count - rd0, 3 * FL);
        for (int k = 0; k < FL; k++) begin
            check_eq("t6_mem0", mem[0][k], 32'(2 * FL + k));
            check_eq("t6_mem1", mem[1][k], 32'(FL + k));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
